// File: rtl/mem_pkg.sv
// Shared geometry, FSM state type and access-size helper for the direct-mapped data cache.
package mem_pkg;

  localparam int BLOCK_SIZE  = 128;
  localparam int OFFSET_BITS = 4;
  localparam int INDEX_BITS  = 4;
  localparam int TAG_BITS    = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int NUM_LINES   = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  // Size encoding 2'b11 is treated as a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_cache_ctrl_store_merge.sv
// Combinational insertion of 1/2/4 right-aligned store bytes into a cache line at a byte offset.
module store_merge
  import mem_pkg::*;
(
  input  logic [BLOCK_SIZE-1:0]  line,
  input  logic [OFFSET_BITS-1:0] offset,
  input  logic [1:0]             size,
  input  logic [31:0]            wdata,
  output logic [BLOCK_SIZE-1:0]  merged
);

  logic [2:0] nbytes;
  logic [4:0] pos;

  always_comb begin
    merged = line;
    nbytes = size_bytes(size);
    pos    = '0;
    for (int b = 0; b < 4; b++) begin
      pos = {1'b0, offset} + 5'(b);
      // Bytes that would run past the end of the line are dropped.
      if ((3'(b) < nbytes) && !pos[4]) begin
        merged[{pos[3:0], 3'b000} +: 8] = wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with a 3-state refill FSM.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module data_cache_ctrl
  import mem_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  input  logic                   we_i,
  input  logic [2:0]             funct3_i,
  input  logic [31:0]            addr_i,
  input  logic [31:0]            wdata_i,
  output logic                   stall_o,
  output logic [BLOCK_SIZE-1:0]  block_o,
  output logic [OFFSET_BITS-1:0] offset_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [31:0]            mem_addr_o,
  output logic [BLOCK_SIZE-1:0]  mem_wdata_o,
  input  logic                   mem_ready_i,
  input  logic [BLOCK_SIZE-1:0]  mem_rdata_i,
`ifdef DCACHE_STATS_EN
  output logic [31:0]            hit_count_o,
  output logic [31:0]            miss_count_o,
`endif
  output state_t                 state_o
);

  // Backing-memory handshake: mem_req_o stays high with stable address/data
  // until mem_ready_i is seen in WRITEBACK or ALLOCATE; mem_ready_i is ignored elsewhere.

  state_t state_q, state_d;

  logic [NUM_LINES-1:0]  valid_q;
  logic [NUM_LINES-1:0]  dirty_q;
  logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
  logic [BLOCK_SIZE-1:0] data_q [NUM_LINES];

  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic                  store_en;
  logic                  refill_en;
  logic                  wb_done;
  logic                  hit_ev;
  logic                  miss_ev;
  logic [BLOCK_SIZE-1:0] merged;
  logic                  unused_funct3;

  assign index         = addr_i[OFFSET_BITS +: INDEX_BITS];
  assign tag           = addr_i[31 -: TAG_BITS];
  assign hit           = req_valid_i && valid_q[index] && (tag_q[index] == tag);
  assign offset_o      = addr_i[OFFSET_BITS-1:0];
  assign state_o       = state_q;
  assign unused_funct3 = funct3_i[2];

  store_merge u_store_merge (
    .line   (data_q[index]),
    .offset (addr_i[OFFSET_BITS-1:0]),
    .size   (funct3_i[1:0]),
    .wdata  (wdata_i),
    .merged (merged)
  );

  always_comb begin
    state_d     = state_q;
    stall_o     = 1'b0;
    block_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    store_en    = 1'b0;
    refill_en   = 1'b0;
    wb_done     = 1'b0;
    hit_ev      = 1'b0;
    miss_ev     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (hit) begin
            block_o  = data_q[index];
            store_en = we_i;
            hit_ev   = 1'b1;
          end else begin
            stall_o = 1'b1;
            miss_ev = 1'b1;
            state_d = (valid_q[index] && dirty_q[index]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        stall_o     = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {tag_q[index], index, {OFFSET_BITS{1'b0}}};
        mem_wdata_o = data_q[index];
        if (mem_ready_i) begin
          wb_done = 1'b1;
          state_d = ALLOCATE;
        end
      end
      ALLOCATE: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = {tag, index, {OFFSET_BITS{1'b0}}};
        if (mem_ready_i) begin
          refill_en = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset forces every visible output quiet, even with a request held.
    if (rst_i) begin
      state_d     = IDLE;
      stall_o     = 1'b0;
      block_o     = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      store_en    = 1'b0;
      refill_en   = 1'b0;
      wb_done     = 1'b0;
      hit_ev      = 1'b0;
      miss_ev     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (refill_en) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end else if (wb_done) begin
        dirty_q[index] <= 1'b0;
      end else if (store_en) begin
        dirty_q[index] <= 1'b1;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (refill_en) begin
      data_q[index] <= mem_rdata_i;
      tag_q[index]  <= tag;
    end else if (store_en) begin
      data_q[index] <= merged;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_count_o  <= '0;
      miss_count_o <= '0;
    end else begin
      if (hit_ev)  hit_count_o  <= hit_count_o + 32'd1;
      if (miss_ev) miss_count_o <= miss_count_o + 32'd1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = hit_ev ^ miss_ev;
`endif

endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 Parameter/constant BLOCK_SIZE, 128, line width in bits (from mem_pkg).
REQ-002 Parameter/constant OFFSET_BITS, 4, byte offset within a line (from mem_pkg).
REQ-003 Parameter/constant INDEX_BITS, 4, line index bits; 16 lines (from mem_pkg).
REQ-004 Port clk_i  in  1  single clock; all state on rising edge.
REQ-005 Port rst_i  in  1  reset, asynchronous, active-high.
REQ-006 Port req_valid_i  in  1  CPU access request this cycle.
REQ-007 Port we_i  in  1  1 = store, 0 = load.
REQ-008 Port funct3_i  in  3  access size; bits[1:0]: 00 byte, 01 half, 10 word.
REQ-009 Port addr_i  in  32  byte address.
REQ-010 Port wdata_i  in  32  store data, right-aligned.
REQ-011 Port stall_o  out  1  request not completed this cycle; CPU holds inputs.
REQ-012 Port block_o  out  BLOCK_SIZE  hit line data for the load-extension stage.
REQ-013 Port offset_o  out  OFFSET_BITS  addr_i[OFFSET_BITS-1:0], passed to the load-extension stage.
REQ-014 Ports mem_req_o out 1, mem_we_o out 1, mem_addr_o out 32 (line-aligned), mem_wdata_o out BLOCK_SIZE: backing-memory request.
REQ-015 Ports mem_ready_i in 1, mem_rdata_i in BLOCK_SIZE: backing-memory completion and refill data.

Function
REQ-016 Direct-mapped, write-back, write-allocate; per line: valid, dirty, tag (32-INDEX_BITS-OFFSET_BITS bits), data.
REQ-017 Hit = req_valid_i & valid[index] & tag match, evaluated combinationally in IDLE.
REQ-018 Load hit: block_o = line data, stall_o = 0 in the same cycle; zero-cycle latency.
REQ-019 Store hit: bytes at offset, 1/2/4 by funct3_i[1:0], written on the next clock edge; dirty set; stall_o = 0.
REQ-020 Store bytes beyond line end are dropped; no other line is modified.
REQ-021 FSM states IDLE, WRITEBACK, ALLOCATE.
REQ-022 IDLE, miss, victim valid & dirty -> WRITEBACK; miss otherwise -> ALLOCATE; stall_o = 1 from the miss cycle.
REQ-023 WRITEBACK: mem_req_o = 1, mem_we_o = 1, mem_addr_o = {victim tag, index, 0}, mem_wdata_o = victim line; on mem_ready_i -> ALLOCATE, dirty cleared.
REQ-024 ALLOCATE: mem_req_o = 1, mem_we_o = 0, mem_addr_o = {addr tag, index, 0}; on mem_ready_i line <= mem_rdata_i, valid = 1, dirty = 0, tag written, -> IDLE.
REQ-025 After refill, the held request hits in IDLE on the next cycle; a store completes then.
REQ-026 mem_req_o held high until mem_ready_i; mem_ready_i outside WRITEBACK/ALLOCATE is ignored.
REQ-027 req_valid_i = 0 in IDLE: stall_o = 0, no state change, mem_req_o = 0.
REQ-028 funct3_i[1:0] = 11 treated as word.

Reset
REQ-029 rst_i asserted: FSM -> IDLE, all valid and dirty bits 0 immediately; data/tag arrays need not reset.
REQ-030 During reset: stall_o = 0, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, block_o = 0.
REQ-031 Reset mid-WRITEBACK/ALLOCATE abandons the transfer; a late mem_ready_i is ignored.

Configuration
REQ-032 Macro DCACHE_STATS_EN defined: 32-bit outputs hit_count_o, miss_count_o; increment once per completed hit and once per miss entry; reset to 0; wrap at 2^32.
REQ-033 Without DCACHE_STATS_EN: counter ports and logic absent; behaviour otherwise identical.

Structure
REQ-034 BLOCK_SIZE, OFFSET_BITS, INDEX_BITS, derived TAG_BITS and the FSM state enum live in mem_pkg.
REQ-035 One sub-module, store_merge: combinational byte insertion of wdata_i into a line at an offset/size.

Verification
REQ-036 Reset, load 0x00000010 -> miss, ALLOCATE, mem_addr_o = 0x10; refill 0x..DDCCBBAA in low word -> next cycle stall_o = 0, block_o = refill, offset_o = 0.
REQ-037 Store byte 0x5A at 0x00000013 after REQ-036 -> no stall; subsequent load 0x10 shows byte 3 = 0x5A, dirty = 1.
REQ-038 Load 0x00000110 (same index, new tag) -> WRITEBACK with mem_addr_o = 0x10, merged line, then ALLOCATE at 0x110.
REQ-039 Store half at offset 15 -> only byte 15 written; bytes 0-14 unchanged.
REQ-040 Assert rst_i during ALLOCATE with mem_ready_i delayed -> FSM IDLE, load to same address misses again.
REQ-041 With DCACHE_STATS_EN: sequence miss, hit, hit -> miss_count_o = 1, hit_count_o = 2.
